trail_writer: RTL and testbench

TRAIL_WRITER -- requirements
Module: trail_writer

---
 rtl/tron_pkg.sv | 41 ++++
 rtl/frame_tick_sync.sv | 40 ++++
 rtl/trail_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_trail_writer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tron_pkg
//  Description : Shared definitions for the light-cycle trail renderer.
//                Holds the screen-size defaults, the colour nibbles, the
//                trail writer state type and two small helpers for the
//                two-pixels-per-word frame-buffer layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package tron_pkg;

    localparam int          c_screen_w     = 640;
    localparam int          c_screen_h     = 480;
    localparam logic [3:0]  c_bg_color     = 4'h8;
    localparam logic [3:0]  c_red_color    = 4'h1;
    localparam logic [3:0]  c_blue_color   = 4'h2;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RED   = 2'd2,
        BLUE  = 2'd3
    } trail_state_t;

    // Word address of a pixel; the caller passes x already halved because
    // two horizontally adjacent pixels share one 16-bit word.
    function automatic logic [18:0] pixel_word_addr(
        input logic [8:0]  x_half,
        input logic [9:0]  y,
        input logic [18:0] half_w
    );
        return {10'd0, x_half} + ({9'd0, y} * half_w);
    endfunction

    // Both pixels of the word get the same colour nibble.
    function automatic logic [15:0] pixel_pair(input logic [3:0] color);
        return {4'h0, color, 4'h0, color};
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_sync
//  Description : Brings the asynchronous frame strobe into the Clk domain
//                through a two-flop synchroniser and turns each rising edge
//                into a single-cycle frame_tick.
//  Ports       : Clk        - system clock
//                Reset      - synchronous, active-low reset
//                frame_clk  - ~60 Hz strobe, asynchronous to Clk
//                frame_tick - one-cycle pulse per frame_clk rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // r_sync3 is only the previous value of the synchronised strobe.
    assign frame_tick = r_sync2 & ~r_sync3;

endmodule
`default_nettype wire

// File: rtl/trail_writer.sv
`default_nettype none
// ============================================================================
//  Module      : trail_writer
//  Description : Writes the two bike trail pixels into the frame buffer once
//                per frame and optionally sweeps the whole buffer to the
//                background colour.
//  Build option: TRAIL_CLEAR_EN - when defined, the CLEAR sweep, start_clear
//                handling and clear_done are built in and reset enters CLEAR.
//                When undefined, start_clear is ignored and clear_done is 0.
//  Ports       : Clk, Reset          - clock, synchronous active-low reset
//                frame_clk           - asynchronous frame strobe
//                start_clear         - one-cycle request to wipe the buffer
//                red_x/y, blue_x/y   - bike pixel positions
//                Data_In             - frame-buffer write data
//                write_address       - frame-buffer word address
//                WE                  - frame-buffer write enable
//                busy                - high whenever not IDLE
//                clear_done          - one-cycle pulse after the last sweep write
//  Revision    : 1.0 - initial release
// ============================================================================
module trail_writer
    import tron_pkg::*;
#(
    parameter int          SCREEN_W   = c_screen_w,
    parameter int          SCREEN_H   = c_screen_h,
    parameter logic [3:0]  BG_COLOR   = c_bg_color,
    parameter logic [3:0]  RED_COLOR  = c_red_color,
    parameter logic [3:0]  BLUE_COLOR = c_blue_color
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start_clear,
    input  logic [9:0]  red_x,
    input  logic [9:0]  red_y,
    input  logic [9:0]  blue_x,
    input  logic [9:0]  blue_y,
    output logic [15:0] Data_In,
    output logic [18:0] write_address,
    output logic        WE,
    output logic        busy,
    output logic        clear_done
);

    localparam logic [18:0] c_half_w = 19'(SCREEN_W / 2);

    trail_state_t r_state;
    trail_state_t w_next;

    logic        w_frame_tick;
    logic        w_latch;
    logic [9:0]  r_red_x, r_red_y, r_blue_x, r_blue_y;
    logic [9:0]  w_red_x, w_red_y, w_blue_x, w_blue_y;

    logic        w_clear_req;     // start_clear accepted out of IDLE
    logic        w_clear_after;   // BLUE hands over to CLEAR instead of IDLE
    logic        w_clr_issue;     // a sweep write is due this edge
    logic        w_clr_last;      // sweep finished, leave CLEAR
    logic [18:0] w_clr_addr;

    logic        w_we;
    logic [18:0] w_addr;
    logic [15:0] w_data;
    logic        w_clear_done;

    logic        r_we;
    logic [18:0] r_addr;
    logic [15:0] r_data;
    logic        r_clear_done;

    function automatic logic fits_screen(input logic [9:0] x, input logic [9:0] y);
        return ({22'd0, x} < 32'(SCREEN_W)) && ({22'd0, y} < 32'(SCREEN_H));
    endfunction

    frame_tick_sync u_tick_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (w_frame_tick)
    );

`ifdef TRAIL_CLEAR_EN
    localparam trail_state_t c_reset_state = CLEAR;
    localparam logic [18:0]  c_words       = 19'((SCREEN_W / 2) * SCREEN_H);

    logic [18:0] r_clr_cnt;       // next sweep address to write
    logic        r_pending;       // clear requested while a trail pair was in flight

    assign w_clear_req   = start_clear;
    assign w_clear_after = r_pending | start_clear;
    assign w_clr_issue   = (r_state == CLEAR) && (r_clr_cnt != c_words);
    assign w_clr_last    = (r_state == CLEAR) && (r_clr_cnt == c_words);
    assign w_clr_addr    = r_clr_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_clr_cnt <= '0;
            r_pending <= 1'b0;
        end else begin
            // Any entry into CLEAR starts from address 0; the first CLEAR
            // cycle is spent with the counter at 0 and no write yet.
            if (w_next != CLEAR) begin
                r_clr_cnt <= '0;
            end else if (w_clr_issue) begin
                r_clr_cnt <= r_clr_cnt + 19'd1;
            end

            if (w_next == CLEAR) begin
                r_pending <= 1'b0;
            end else if (start_clear && ((r_state == RED) || (r_state == BLUE))) begin
                r_pending <= 1'b1;
            end
        end
    end
`else
    localparam trail_state_t c_reset_state = IDLE;

    logic w_unused_start_clear;

    assign w_unused_start_clear = start_clear;
    assign w_clear_req          = 1'b0;
    assign w_clear_after        = 1'b0;
    assign w_clr_issue          = 1'b0;
    assign w_clr_last           = 1'b0;
    assign w_clr_addr           = '0;
`endif

    // Coordinates are captured on the accepted tick; the red write uses the
    // live inputs on that same edge so it appears in the very next cycle.
    assign w_latch  = (r_state == IDLE) && w_frame_tick && !w_clear_req;
    assign w_red_x  = w_latch ? red_x  : r_red_x;
    assign w_red_y  = w_latch ? red_y  : r_red_y;
    assign w_blue_x = w_latch ? blue_x : r_blue_x;
    assign w_blue_y = w_latch ? blue_y : r_blue_y;

    // ---------------------------------------------------------------- state
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= c_reset_state;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_clear_req) begin
                    w_next = CLEAR;
                end else if (w_frame_tick) begin
                    w_next = RED;
                end
            end
            RED:     w_next = BLUE;
            BLUE:    w_next = w_clear_after ? CLEAR : IDLE;
            CLEAR:   w_next = w_clr_issue ? CLEAR : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // --------------------------------------------------------------- output
    // Outputs are computed for the state being entered and registered, so
    // they line up with that state and are clean zero while in reset.
    always_comb begin
        w_we         = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        w_clear_done = w_clr_last;
        case (w_next)
            RED: begin
                if (fits_screen(w_red_x, w_red_y)) begin
                    w_we   = 1'b1;
                    w_addr = pixel_word_addr(w_red_x[9:1], w_red_y, c_half_w);
                    w_data = pixel_pair(RED_COLOR);
                end
            end
            BLUE: begin
                if (fits_screen(w_blue_x, w_blue_y)) begin
                    w_we   = 1'b1;
                    w_addr = pixel_word_addr(w_blue_x[9:1], w_blue_y, c_half_w);
                    w_data = pixel_pair(BLUE_COLOR);
                end
            end
            CLEAR: begin
                if (w_clr_issue) begin
                    w_we   = 1'b1;
                    w_addr = w_clr_addr;
                    w_data = pixel_pair(BG_COLOR);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_clear_done <= 1'b0;
            r_red_x      <= '0;
            r_red_y      <= '0;
            r_blue_x     <= '0;
            r_blue_y     <= '0;
        end else begin
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_data       <= w_data;
            r_clear_done <= w_clear_done;
            if (w_latch) begin
                r_red_x  <= red_x;
                r_red_y  <= red_y;
                r_blue_x <= blue_x;
                r_blue_y <= blue_y;
            end
        end
    end

    assign WE            = r_we;
    assign write_address = r_addr;
    assign Data_In       = r_data;
    assign clear_done    = r_clear_done;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trail_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trail_writer
//  Description : Self-checking bench for trail_writer. A behavioural model
//                keeps a queue of the writes the frame buffer should see and
//                is compared with the DUT every cycle; a constant vector
//                table and short directed sequences cover the corner cases.
//                With TRAIL_CLEAR_EN a small screen keeps the sweep short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trail_writer;

`ifdef TRAIL_CLEAR_EN
    localparam int W = 32;
    localparam int H = 8;
    localparam bit CLR_EN = 1'b1;
`else
    localparam int W = 640;
    localparam int H = 480;
    localparam bit CLR_EN = 1'b0;
`endif
    localparam int NWORDS      = (W / 2) * H;
    localparam int RED_C       = 1;
    localparam int BLUE_C      = 2;
    localparam int BG_C        = 8;
    localparam int RAND_CYCLES = 4000;
    localparam int K_IDLE = 0, K_RED = 1, K_BLUE = 2, K_CLR = 3;

    logic        clk = 1'b0;
    logic        rst_n, frame_clk, start_clear;
    logic [9:0]  red_x, red_y, blue_x, blue_y;
    logic [15:0] Data_In;
    logic [18:0] write_address;
    logic        WE, busy, clear_done;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    trail_writer #(
        .SCREEN_W (W),
        .SCREEN_H (H)
    ) dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .frame_clk     (frame_clk),
        .start_clear   (start_clear),
        .red_x         (red_x),
        .red_y         (red_y),
        .blue_x        (blue_x),
        .blue_y        (blue_y),
        .Data_In       (Data_In),
        .write_address (write_address),
        .WE            (WE),
        .busy          (busy),
        .clear_done    (clear_done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ reference
    typedef struct {
        bit we;
        int addr;
        int data;
        bit done;
        bit busy;
        int kind;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   pend;
    bit   f1, f2, f3;   // frame_clk as seen at the last three edges

    function automatic exp_t idle_rec();
        exp_t e;
        e.we = 0; e.addr = 0; e.data = 0; e.done = 0; e.busy = 0; e.kind = K_IDLE;
        return e;
    endfunction

    function automatic exp_t pixel_write(int x, int y, int color, int kind);
        exp_t e;
        e = idle_rec();
        e.busy = 1;
        e.kind = kind;
        if (x < W && y < H) begin
            e.we   = 1;
            e.addr = x / 2 + y * (W / 2);
            e.data = color * 257;
        end
        return e;
    endfunction

    task automatic push_clear();
        exp_t e;
        e = idle_rec();
        e.busy = 1;
        e.kind = K_CLR;
        q.push_back(e);
        for (int a = 0; a < NWORDS; a++) begin
            e.we = 1; e.addr = a; e.data = BG_C * 257;
            q.push_back(e);
        end
        e = idle_rec();
        e.done = 1;
        q.push_back(e);
    endtask

    task automatic model_step();
        bit tick, sc;
        // a rising edge two samples back reaches the FSM now
        tick = f2 & ~f3;
        f3 = f2; f2 = f1; f1 = (rst_n === 1'b1) ? frame_clk : 1'b0;
        if (rst_n !== 1'b1) begin
            q.delete();
            pend = 0; f1 = 0; f2 = 0; f3 = 0;
            if (CLR_EN) begin
                push_clear();
                cur = q.pop_front();
            end else begin
                cur = idle_rec();
            end
        end else begin
            sc = CLR_EN && (start_clear === 1'b1);
            if (q.size() > 0) begin
                if (sc && (cur.kind == K_RED || cur.kind == K_BLUE)) pend = 1;
                cur = q.pop_front();
            end else if (!cur.busy) begin
                if (sc) begin
                    push_clear();
                    cur = q.pop_front();
                end else if (tick) begin
                    q.push_back(pixel_write(blue_x, blue_y, BLUE_C, K_BLUE));
                    cur = pixel_write(red_x, red_y, RED_C, K_RED);
                end else begin
                    cur = idle_rec();
                end
            end else if (cur.kind == K_BLUE && (pend || sc)) begin
                pend = 0;
                push_clear();
                cur = q.pop_front();
            end else begin
                cur = idle_rec();
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc_n++;
        model_step();
        checks++;
        if (WE !== cur.we || write_address !== 19'(cur.addr) || Data_In !== 16'(cur.data) ||
            clear_done !== cur.done || busy !== cur.busy) begin
            errors++;
            $display("FAIL model cycle %0d: got we=%b addr=%0d data=%h done=%b busy=%b, want we=%b addr=%0d data=%h done=%b busy=%b",
                     cyc_n, WE, write_address, Data_In, clear_done, busy,
                     cur.we, cur.addr, 16'(cur.data), cur.done, cur.busy);
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check(string nm, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic longint dut_word();
        return longint'({WE, write_address, Data_In});
    endfunction

    function automatic longint exp_word(bit we, int addr, int data);
        if (!we) return 0;
        return (longint'(1) << 35) | (longint'(addr) << 16) | longint'(data);
    endfunction

    task automatic sweep(string tag);
        int nw = 0;
        int nd = 0;
        bit ord = 1;
        for (int i = 0; i < NWORDS + 10; i++) begin
            cyc();
            if (WE === 1'b1) begin
                if (write_address !== 19'(nw) || Data_In !== 16'h0808) ord = 0;
                nw++;
            end
            if (clear_done === 1'b1) nd++;
        end
        check({tag, "_writes"}, nw, NWORDS);
        check({tag, "_order"}, ord, 1);
        check({tag, "_done_pulses"}, nd, 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    // ------------------------------------------------------------- vectors
    typedef struct {
        int rx, ry, bx, by;
        bit rwe;
        int raddr;
        bit bwe;
        int baddr;
    } vec_t;

    vec_t vt[7];

    initial begin
        int hold;
        bit any_we, any_done, any_busy, found;

        vt[0] = '{rx:100,  ry:50,   bx:639,  by:479, rwe:1, raddr:16050, bwe:1, baddr:153599};
        vt[1] = '{rx:640,  ry:10,   bx:0,    by:0,   rwe:0, raddr:0,     bwe:1, baddr:0};
        vt[2] = '{rx:5,    ry:0,    bx:5,    by:0,   rwe:1, raddr:2,     bwe:1, baddr:2};
        vt[3] = '{rx:0,    ry:480,  bx:1,    by:479, rwe:0, raddr:0,     bwe:1, baddr:153280};
        vt[4] = '{rx:1023, ry:1023, bx:638,  by:0,   rwe:0, raddr:0,     bwe:1, baddr:319};
        vt[5] = '{rx:3,    ry:1,    bx:1023, by:5,   rwe:1, raddr:321,   bwe:0, baddr:0};
        vt[6] = '{rx:639,  ry:0,    bx:0,    by:1,   rwe:1, raddr:319,   bwe:1, baddr:320};

        rst_n = 1'b0; frame_clk = 1'b0; start_clear = 1'b0;
        red_x = '0; red_y = '0; blue_x = '0; blue_y = '0;
        cycles(3);
        check("reset_outputs", dut_word(), 0);
        check("reset_clear_done", clear_done, 0);
        check("reset_busy", busy, CLR_EN);
        rst_n = 1'b1;

`ifndef TRAIL_CLEAR_EN
        cycles(2);
        for (int i = 0; i < 7; i++) begin
            red_x = 10'(vt[i].rx); red_y = 10'(vt[i].ry);
            blue_x = 10'(vt[i].bx); blue_y = 10'(vt[i].by);
            frame_clk = 1'b1;
            cycles(3);
            frame_clk = 1'b0;
            check($sformatf("vec%0d_red", i), dut_word(), exp_word(vt[i].rwe, vt[i].raddr, RED_C * 257));
            cyc();
            check($sformatf("vec%0d_blue", i), dut_word(), exp_word(vt[i].bwe, vt[i].baddr, BLUE_C * 257));
            cyc();
            check($sformatf("vec%0d_idle", i), dut_word(), 0);
            check($sformatf("vec%0d_busy", i), busy, 0);
            cycles(2);
        end

        // start_clear has no effect in this build
        start_clear = 1'b1;
        any_we = 0; any_done = 0; any_busy = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            start_clear = 1'b0;
            any_we |= (WE !== 1'b0);
            any_done |= (clear_done !== 1'b0);
            any_busy |= (busy !== 1'b0);
        end
        check("noclear_we", any_we, 0);
        check("noclear_done", any_done, 0);
        check("noclear_busy", any_busy, 0);

        // reset in the middle of the RED write
        red_x = 10'd20; red_y = 10'd2; blue_x = 10'd40; blue_y = 10'd3;
        frame_clk = 1'b1;
        cycles(3);
        check("pre_reset_red", dut_word(), exp_word(1, 10 + 2 * 320, RED_C * 257));
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        frame_clk = 1'b0;
        check("midreset_outputs", dut_word(), 0);
        check("midreset_busy", busy, 0);
        cycles(3);
`else
        sweep("init");

        // start_clear during RED: blue write first, then the sweep
        red_x = 10'd2; red_y = 10'd1; blue_x = 10'd4; blue_y = 10'd2;
        frame_clk = 1'b1;
        cycles(3);
        start_clear = 1'b1;
        cyc();
        start_clear = 1'b0;
        frame_clk = 1'b0;
        check("pend_blue", dut_word(), exp_word(1, 2 + 2 * (W / 2), BLUE_C * 257));
        sweep("pending");

        // reset mid-sweep restarts from address 0
        start_clear = 1'b1;
        cyc();
        start_clear = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            cyc();
            found = (WE === 1'b1) && (write_address == 19'd5);
        end
        check("reach_addr5", found, 1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        sweep("restart");
`endif

        // randomized traffic against the model
        hold = 0;
        for (int i = 0; i < RAND_CYCLES; i++) begin
            if (hold == 0) begin
                frame_clk = ~frame_clk;
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            red_x  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, W + W / 8));
            red_y  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, H + H / 8));
            blue_x = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, W + W / 8));
            blue_y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, H + H / 8));
            start_clear = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rst_n = 1'b1;
        start_clear = 1'b0;
        cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
